seg7_scan_mux: RTL
==================

Name: seg7_scan_mux

Overview:
- Parametrised multiplexed 7-segment display driver; next generation of the team's fixed 4-digit hex scanner.
- Scans N_DIGITS hex digits with per-digit decimal points, a blanking gap between digits, and 16-level brightness.
- Provides optional leading-zero suppression, selectable output polarities, and tear-free double-buffered loading.
- Sits between the CPU debug/status registers and the board's digit-enable and segment pins.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (1..8).
- DIG_CYCLES, 15008, on-phase length per digit in CLK cycles; must be a multiple of 16 and at least 16.
- GAP_CYCLES, 16, blanking cycles before each digit's on-phase, with all enables inactive (0 allowed).
- EN_ACTIVE_LOW, 1, 1 = digit enable asserted low.
- SEG_ACTIVE_LOW, 0, 1 = segment and DP outputs inverted.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous active-high reset.
- data_in  input  4*N_DIGITS  hex nibbles; nibble k = bits [4k+3:4k] drives digit k (digit 0 = least significant).
- dp_in  input  N_DIGITS  decimal point per digit.
- load  input  1  single-cycle strobe; captures data_in/dp_in into the shadow register.
- lz_en  input  1  leading-zero suppression enable (sampled each cycle).
- brightness  input  4  duty level 0..15, sampled at the start of each digit slot.
- seg  output  7  {g,f,e,d,c,b,a}, registered.
- seg_dp  output  1  decimal point, registered.
- dig_en  output  N_DIGITS  digit enables; bit k selects digit k; registered.
- frame_done  output  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset, asynchronous:
  - dig_en all inactive (all ones if EN_ACTIVE_LOW=1).
  - seg and seg_dp at their unlit level.
  - frame_done 0; digit index 0; phase = GAP (or ON if GAP_CYCLES=0).
  - Shadow and display registers cleared to 0.
- Digit slot: GAP phase (GAP_CYCLES cycles), then ON phase (DIG_CYCLES cycles).
  - Frame length = N_DIGITS*(GAP_CYCLES+DIG_CYCLES).
  - Digit index wraps from N_DIGITS-1 to 0.
- States:
  - GAP: all enables inactive; segments unlit; cycle counter counts to GAP_CYCLES-1, then -> ON.
  - ON: counter counts to DIG_CYCLES-1, then -> GAP for the next digit.
- Brightness in ON: dig_en[idx] is asserted for the first (brightness+1)*(DIG_CYCLES/16) cycles, inactive for the rest.
  - brightness=15 gives the full on-phase.
  - Segments stay driven for the whole ON phase.
- Decode, hex 0-F:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8=7F, 9=6F, A=77, B=7C, C=58, D=5E, E=79, F=71.
  - Blank = 00. Inverted when SEG_ACTIVE_LOW=1.
- Leading-zero suppression (lz_en=1):
  - Digit k is blanked (seg=00, dp unlit) when k>0 and nibbles k..N_DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - A set DP on a suppressed digit is also blanked.
- Double buffering:
  - load writes the shadow register on the same edge; no effect on the current frame.
  - The display register copies the shadow on the edge where frame_done is asserted.
  - New data first appears at digit 0 of the next frame.
  - Multiple loads within one frame: the last one wins.
  - A load coinciding with frame_done captures into the shadow; display takes the previous shadow value, and the new value shows one frame later.
- Output latency: seg, seg_dp and dig_en are registered, 1 cycle after the internal phase/index state.
- frame_done: high for the final cycle of digit N_DIGITS-1's ON phase.
- RST mid-frame: immediate return to reset values; scanning restarts from digit 0 GAP after release.

Test Plan:
- Parameters N_DIGITS=4, DIG_CYCLES=32, GAP_CYCLES=2, EN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0 unless stated.
- Reset then load data_in=16'h12AF, brightness=15 -> after the first frame_done, per slot:
  - digit 0: dig_en=4'b1110, seg=7'h71;
  - digit 1: dig_en=4'b1101, seg=7'h77;
  - digit 2: dig_en=4'b1011, seg=7'h5B;
  - digit 3: dig_en=4'b0111, seg=7'h06;
  - each for 32 cycles, separated by 2 cycles of dig_en=4'b1111; frame_done period 136 cycles.
- brightness=3 -> dig_en asserted 8 of 32 ON cycles per digit; brightness=0 -> 2 cycles.
- lz_en=1, data_in=16'h0050 -> digits 3 and 2 blank (seg=00, dig_en still scanned); digit 1 shows 6D; digit 0 shows 3F. data_in=16'h0000 -> only digit 0 shows 3F.
- Load 16'h1111 mid-frame, then 16'h2222 in the same frame -> current frame unchanged; next frame shows 2222 on all digits; 1111 never displayed.
- Assert RST during digit 2 ON -> the same cycle shows dig_en=4'b1111, seg=00, frame_done=0; after release, digit 0 restarts following 2 gap cycles, displaying 0000.
- N_DIGITS=6, SEG_ACTIVE_LOW=1, dp_in=6'b000100 -> 6-slot scan; digit 2 has seg_dp=0; digit showing 8 drives seg=7'h00.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// Multiplexed hex 7-segment scanner with blanking gap,
// 16-level brightness, zero suppression and double buffering.
module seg7_scan_mux #(
  parameter int N_DIGITS       = 4,
  parameter int DIG_CYCLES     = 15008,
  parameter int GAP_CYCLES     = 16,
  parameter bit EN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic [3:0]            brightness,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [N_DIGITS-1:0]   dig_en,
  output logic                  frame_done
);

  localparam int MAXC =
    (DIG_CYCLES > GAP_CYCLES) ? DIG_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC);
  localparam int IW =
    (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int STEP = DIG_CYCLES / 16;

  localparam logic [CW-1:0] DIG_LAST =
    CW'(DIG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(N_DIGITS - 1);

  typedef enum logic {S_GAP, S_ON} state_t;

  // First phase of every slot; GAP is skipped when it has no length
  localparam state_t S_INIT =
    (GAP_CYCLES == 0) ? S_ON : S_GAP;

  localparam logic [6:0] SEG_INV =
    {7{SEG_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] EN_INV =
    {N_DIGITS{EN_ACTIVE_LOW}};

  state_t  state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;

  logic [3:0] bright_q;
  logic [3:0] bright_eff;
  logic       slot_start;

  logic [4*N_DIGITS-1:0] sh_data, ds_data;
  logic [N_DIGITS-1:0]   sh_dp, ds_dp;

  logic [N_DIGITS-1:0] zero_up;
  logic                zacc;
  logic                blank;
  logic [3:0]          nib;
  logic [31:0]         lim;
  logic                lit;

  logic [6:0]          seg_raw;
  logic                dp_raw;
  logic [N_DIGITS-1:0] en_raw;

  function automatic logic [6:0] hex7(
    input logic [3:0] n
  );
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h58;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_INIT;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    unique case (state)
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = S_ON;
          cnt_n   = '0;
        end
      end
      S_ON: begin
        if (cnt == DIG_LAST) begin
          state_n = S_INIT;
          cnt_n   = '0;
          idx_n   = (idx == IDX_LAST) ?
                    '0 : idx + 1'b1;
        end
      end
    endcase
  end

  assign frame_done = (state == S_ON) &&
                      (idx == IDX_LAST) &&
                      (cnt == DIG_LAST);

  assign slot_start = (state == S_INIT) &&
                      (cnt == '0);
  assign bright_eff = slot_start ?
                      brightness : bright_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bright_q <= 4'hF;
    end else if (slot_start) begin
      bright_q <= brightness;
    end
  end

  // Display copy uses the pre-load shadow when both coincide
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_data <= '0;
      sh_dp   <= '0;
      ds_data <= '0;
      ds_dp   <= '0;
    end else begin
      if (load) begin
        sh_data <= data_in;
        sh_dp   <= dp_in;
      end
      if (frame_done) begin
        ds_data <= sh_data;
        ds_dp   <= sh_dp;
      end
    end
  end

  // zero_up[k]: nibbles k..N_DIGITS-1 are all zero
  always_comb begin
    zero_up = '0;
    zacc    = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zacc       = zacc && (ds_data[4*k +: 4] == 4'h0);
      zero_up[k] = zacc;
    end
  end

  assign blank = lz_en && (idx != '0) &&
                 zero_up[idx];
  assign nib   = ds_data[4*idx +: 4];
  assign lim   = (32'(bright_eff) + 32'd1) * STEP;
  assign lit   = (32'(cnt) < lim);

  always_comb begin
    seg_raw = '0;
    dp_raw  = 1'b0;
    en_raw  = '0;
    if (state == S_ON) begin
      if (!blank) begin
        seg_raw = hex7(nib);
        dp_raw  = ds_dp[idx];
      end
      en_raw[idx] = lit;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seg    <= SEG_INV;
      seg_dp <= SEG_ACTIVE_LOW;
      dig_en <= EN_INV;
    end else begin
      seg    <= seg_raw ^ SEG_INV;
      seg_dp <= dp_raw ^ SEG_ACTIVE_LOW;
      dig_en <= en_raw ^ EN_INV;
    end
  end

endmodule
